pe_gen: RTL
===========

# pe_gen

Parametrised systolic-array processing element, the next generation of the fixed 16-bit weight-stationary PE. It adds configurable width and fraction bits, round-to-nearest fixed-point multiply, and a registered double-buffered weight swap. A runtime output-stationary mode with an accumulate/drain shift chain and a sticky overflow flag are also new. It tiles into the N×N array exactly like the current PE: inputs flow east, weights and psums flow south.

## Interface
- DATA_WIDTH, 16: width of every data path (input, weight, psum, accumulator).
- FRAC_BITS, 8: fractional bits of the signed fixed-point format; valid range 1 to DATA_WIDTH-2.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high; clears all state immediately.
- pe_enabled  in  1  clock enable; low = every register holds its value.
- pe_mode  in  1  0 = weight-stationary (WS), 1 = output-stationary (OS); quasi-static.
- pe_input_in  in  DATA_WIDTH  signed activation from west.
- pe_valid_in  in  1  activation valid.
- pe_weight_in  in  DATA_WIDTH  signed weight from north.
- pe_accept_w_in  in  1  load pe_weight_in into the inactive weight buffer.
- pe_switch_in  in  1  swap request: inactive buffer -> active.
- pe_psum_in  in  DATA_WIDTH  signed partial sum from north.
- pe_psum_valid_in  in  1  pe_psum_in valid (OS drain chain).
- pe_drain_in  in  1  OS: emit accumulator southward and clear it.
- pe_input_out, pe_weight_out, pe_psum_out  out  DATA_WIDTH  registered east/south outputs.
- pe_valid_out, pe_switch_out, pe_drain_out, pe_psum_valid_out  out  1  registered control propagation.
- pe_overflow  out  1  sticky saturation/wrap flag.

## Operation
- Product: full 2·DATA_WIDTH signed x·w_active, add 2^(FRAC_BITS-1), arithmetic shift right FRAC_BITS, reduce to DATA_WIDTH. Sum: DATA_WIDTH+1-bit add, reduce to DATA_WIDTH. Reduction per Configuration.
- Weights: accept_w -> inactive <= weight_in, weight_out <= weight_in; else weight_out <= 0. switch -> active <= inactive (value before this edge's load). No combinational path from switch to the multiplier.
- Pass-through: input_out <= valid_in ? input_in : 0; valid_out <= valid_in; switch_out <= switch_in; drain_out <= drain_in.
- WS (mode=0): valid_in -> psum_out <= psum_in + prod; else psum_out <= 0. psum_valid_out <= valid_in. Accumulator held at 0.
- OS (mode=1): valid_in -> acc <= acc + prod. drain_in -> psum_out <= acc_next (acc plus prod if valid_in the same cycle), acc <= 0, psum_valid_out <= 1. No drain -> psum_out <= psum_in, psum_valid_out <= psum_valid_in (shift chain).
- Overflow: set on any clipped or wrapped reduction in a used result. Cleared only by rst.

## Timing
- All outputs are registered; every path has 1-cycle latency from inputs to outputs.
- Reset value of every output and internal register: 0.
- An input with valid_in in the same cycle as switch_in uses the old active weight. The new weight applies from the next cycle. switch_out asserts the same cycle the local swap becomes visible to the next PE's inputs.
- accept_w and switch in the same cycle: active <= old inactive, inactive <= new weight.
- pe_enabled low: nothing updates, including overflow; outputs hold.
- Mode change is legal only when idle. Entering WS zeroes acc on the next enabled edge.
- Asserting rst mid-operation clears acc, both weight buffers and overflow at once. The first enabled edge after release behaves as from power-on.

## Configuration
- PE_GEN_SAT_EN defined: product and sum reductions clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- PE_GEN_SAT_EN undefined: reductions truncate (two's-complement wrap). pe_overflow still reports the same events.

## Test plan
- WS MAC (W=16, F=8): load 0x0200, switch, then input 0x0180 with psum_in 0x0100 -> psum_out 0x0400 one cycle later, psum_valid_out=1.
- Rounding: weight 0x0001, input 0x0080 -> product rounds to 0x0001. Input 0x007F -> 0x0000.
- Double buffer: active 0x0100, load 0x0300 with switch the same cycle, input 0x0100 -> psum 0x0100 this cycle, 0x0300 next cycle.
- Overflow: weight 0x7F00, input 0x7F00 -> SAT_EN: psum_out 0x7FFF, overflow=1. Without SAT_EN: wrapped value, overflow=1.
- OS: four valid inputs 0x0100 × weight 0x0100, then drain -> psum_out 0x0400, acc cleared. psum_in 0x1234 with psum_valid_in is forwarded when not draining.
- Async rst asserted between clock edges mid-accumulation -> all outputs 0 immediately. enabled=0 -> outputs frozen for 3 cycles.

Source files
------------

// File: rtl/pe_gen.sv
// pe_gen: parametrised fixed-point systolic PE with weight- and output-stationary modes.
// Define PE_GEN_SAT_EN to clamp product/sum reductions instead of wrapping them.
module pe_gen #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pe_enabled,
    input  logic                         pe_mode,
    input  logic signed [DATA_WIDTH-1:0] pe_input_in,
    input  logic                         pe_valid_in,
    input  logic signed [DATA_WIDTH-1:0] pe_weight_in,
    input  logic                         pe_accept_w_in,
    input  logic                         pe_switch_in,
    input  logic signed [DATA_WIDTH-1:0] pe_psum_in,
    input  logic                         pe_psum_valid_in,
    input  logic                         pe_drain_in,
    output logic signed [DATA_WIDTH-1:0] pe_input_out,
    output logic signed [DATA_WIDTH-1:0] pe_weight_out,
    output logic signed [DATA_WIDTH-1:0] pe_psum_out,
    output logic                         pe_valid_out,
    output logic                         pe_switch_out,
    output logic                         pe_drain_out,
    output logic                         pe_psum_valid_out,
    output logic                         pe_overflow
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam logic signed [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
`ifdef PE_GEN_SAT_EN
    localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
`endif

    if (FRAC_BITS < 1 || FRAC_BITS > DATA_WIDTH - 2) begin : g_bad_frac
        $error("pe_gen: FRAC_BITS must lie in 1..DATA_WIDTH-2");
    end

    function automatic logic signed [PW-1:0] sext(input logic signed [W-1:0] v);
        return {{(PW-W){v[W-1]}}, v};
    endfunction

    // Returns {overflow, reduced value}; overflow means the top W+1 bits are not all sign.
    function automatic logic [W:0] reduce(input logic signed [PW-1:0] v);
        logic         ovf;
        logic [W-1:0] r;
        ovf = (v[PW-1:W-1] != {(W+1){1'b0}}) && (v[PW-1:W-1] != {(W+1){1'b1}});
`ifdef PE_GEN_SAT_EN
        r = ovf ? (v[PW-1] ? SMIN : SMAX) : v[W-1:0];
`else
        r = v[W-1:0];
`endif
        return {ovf, r};
    endfunction

    logic signed [W-1:0] input_q, input_d;
    logic signed [W-1:0] weight_q, weight_d;
    logic signed [W-1:0] psum_q, psum_d;
    logic signed [W-1:0] acc_q, acc_d;
    logic signed [W-1:0] w_active_q, w_active_d;
    logic signed [W-1:0] w_inactive_q, w_inactive_d;
    logic                valid_q, valid_d;
    logic                switch_q, switch_d;
    logic                drain_q, drain_d;
    logic                psum_valid_q, psum_valid_d;
    logic                overflow_q, overflow_d;

    logic signed [PW-1:0] prod_full, prod_shift, sum_full;
    logic [W:0]           prod_red, sum_red;
    logic signed [W-1:0]  prod, sum_a, sum, acc_next;
    logic                 ovf_event;

    // Datapath: the multiplier only ever sees the registered active weight.
    always_comb begin
        prod_full  = sext(pe_input_in) * sext(w_active_q);
        prod_shift = (prod_full + RND) >>> FRAC_BITS;
        prod_red   = reduce(prod_shift);
        prod       = prod_red[W-1:0];
        sum_a      = pe_mode ? acc_q : pe_psum_in;
        sum_full   = sext(sum_a) + sext(prod);
        sum_red    = reduce(sum_full);
        sum        = sum_red[W-1:0];
        acc_next   = pe_valid_in ? sum : acc_q;
        ovf_event  = pe_valid_in && (prod_red[W] || sum_red[W]);
    end

    always_comb begin
        input_d      = pe_valid_in ? pe_input_in : '0;
        valid_d      = pe_valid_in;
        switch_d     = pe_switch_in;
        drain_d      = pe_drain_in;
        weight_d     = pe_accept_w_in ? pe_weight_in : '0;
        w_inactive_d = pe_accept_w_in ? pe_weight_in : w_inactive_q;
        w_active_d   = pe_switch_in ? w_inactive_q : w_active_q;
        overflow_d   = overflow_q | ovf_event;
        acc_d        = acc_q;
        psum_d       = psum_q;
        psum_valid_d = psum_valid_q;
        if (!pe_mode) begin
            acc_d        = '0;
            psum_d       = pe_valid_in ? sum : '0;
            psum_valid_d = pe_valid_in;
        end else if (pe_drain_in) begin
            acc_d        = '0;
            psum_d       = acc_next;
            psum_valid_d = 1'b1;
        end else begin
            acc_d        = acc_next;
            psum_d       = pe_psum_in;
            psum_valid_d = pe_psum_valid_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            input_q      <= '0;
            weight_q     <= '0;
            psum_q       <= '0;
            acc_q        <= '0;
            w_active_q   <= '0;
            w_inactive_q <= '0;
            valid_q      <= 1'b0;
            switch_q     <= 1'b0;
            drain_q      <= 1'b0;
            psum_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else if (pe_enabled) begin
            input_q      <= input_d;
            weight_q     <= weight_d;
            psum_q       <= psum_d;
            acc_q        <= acc_d;
            w_active_q   <= w_active_d;
            w_inactive_q <= w_inactive_d;
            valid_q      <= valid_d;
            switch_q     <= switch_d;
            drain_q      <= drain_d;
            psum_valid_q <= psum_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign pe_input_out      = input_q;
    assign pe_weight_out     = weight_q;
    assign pe_psum_out       = psum_q;
    assign pe_valid_out      = valid_q;
    assign pe_switch_out     = switch_q;
    assign pe_drain_out      = drain_q;
    assign pe_psum_valid_out = psum_valid_q;
    assign pe_overflow       = overflow_q;

endmodule
